// File: rtl/fp_mul_lp_pipe_pkg.sv
// fp_lp_pkg: shared mode encoding and exponent bias helper for the log-product multiplier
package fp_lp_pkg;
  typedef enum logic {MODE_EXACT = 1'b0, MODE_APPROX = 1'b1} mode_e;
  function automatic int bias(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/fp_mul_lp_pipe_if.sv
// fp_mul_lp_pipe_if: operand/result handshake bundle; slave = multiplier side, master = producer/consumer side
interface fp_mul_lp_pipe_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
  logic in_valid, in_ready, sign_x, sign_y, mode;
  logic [EXP_W-1:0] exp_x, exp_y;
  logic [MAN_W-1:0] mantissa_x, mantissa_y;
  logic out_valid, out_ready, sign_out, ovf_out, unf_out;
  logic [EXP_W-1:0] exp_out;
  logic [MAN_W-1:0] mantissa_out;
  modport slave(input in_valid, sign_x, sign_y, exp_x, exp_y, mantissa_x, mantissa_y, mode, out_ready,
                output in_ready, out_valid, sign_out, exp_out, mantissa_out, ovf_out, unf_out);
  modport master(output in_valid, sign_x, sign_y, exp_x, exp_y, mantissa_x, mantissa_y, mode, out_ready,
                 input in_ready, out_valid, sign_out, exp_out, mantissa_out, ovf_out, unf_out);
endinterface

// File: rtl/fp_mul_lp_pipe_mant.sv
// fp_lp_mant_unit: combinational mantissa core, exact truncated product or log-domain sum
// mx/my: stored fractions; mode: 0 exact, 1 approx; mantissa: result fraction; shift: exponent bump
module fp_lp_mant_unit import fp_lp_pkg::*; #(parameter int MAN_W = 23) (
  input  logic [MAN_W-1:0] mx,
  input  logic [MAN_W-1:0] my,
  input  logic             mode,
  output logic [MAN_W-1:0] mantissa,
  output logic             shift
);
  logic [2*MAN_W+1:0] p;
  logic [MAN_W:0] s;
  assign p = (2*MAN_W+2)'({1'b1, mx}) * (2*MAN_W+2)'({1'b1, my});
  assign s = {1'b0, mx} + {1'b0, my};
  // Product of two values in [1,2) lies in [1,4): the top bit selects which window is the fraction
  assign shift = (mode == MODE_APPROX) ? s[MAN_W] : p[2*MAN_W+1];
  assign mantissa = (mode == MODE_APPROX) ? s[MAN_W-1:0] :
                    p[2*MAN_W+1] ? p[2*MAN_W:MAN_W+1] : p[2*MAN_W-1:MAN_W];
endmodule

// File: rtl/fp_mul_lp_pipe.sv
// fp_mul_lp_pipe: two-stage floating-point multiplier with exact/approximate mantissa and saturation counters
// clk/rst_n: clock, async active-low reset; bus: operand/result handshake (slave)
// cnt_clr: sync clear of counters; ovf_cnt/unf_cnt: delivered saturated-high / clamped-low results
module fp_mul_lp_pipe import fp_lp_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_mul_lp_pipe_if.slave  bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(bias(EXP_W));
  localparam logic signed [EXP_W+1:0] E_OVF = (EXP_W+2)'((1 << EXP_W) - 1);
  logic s1_v, s1_sign, s1_mode, s2_v, s1_adv, deliver;
  logic [EXP_W-1:0] s1_ex, s1_ey;
  logic [MAN_W-1:0] s1_mx, s1_my;
  logic [MAN_W-1:0] m_core, r_man;
  logic shift, zero, ovf, unf;
  logic signed [EXP_W+1:0] e;
  logic [EXP_W-1:0] r_exp;
  assign s1_adv = ~s2_v | bus.out_ready;
  assign bus.in_ready = ~s1_v | s1_adv;
  assign bus.out_valid = s2_v;
  assign deliver = s2_v & bus.out_ready;
  always_ff @(posedge clk)
    if (bus.in_valid & bus.in_ready) begin
      s1_sign <= bus.sign_x ^ bus.sign_y;
      s1_ex <= bus.exp_x;
      s1_ey <= bus.exp_y;
      s1_mx <= bus.mantissa_x;
      s1_my <= bus.mantissa_y;
      s1_mode <= bus.mode;
    end
  fp_lp_mant_unit #(.MAN_W(MAN_W)) u_mant (.mx(s1_mx), .my(s1_my), .mode(s1_mode), .mantissa(m_core), .shift(shift));
  // Two guard bits keep the unbiased sum from wrapping in either direction
  assign e = $signed({2'b00, s1_ex}) + $signed({2'b00, s1_ey}) - BIAS_S + $signed({{(EXP_W+1){1'b0}}, shift});
  assign zero = ~|s1_ex | ~|s1_ey;
  assign ovf = ~zero & (e >= E_OVF);
  assign unf = ~zero & ~ovf & (e[EXP_W+1] | ~|e);
  assign r_exp = zero ? '0 : ovf ? {{(EXP_W-1){1'b1}}, 1'b0} : unf ? EXP_W'(1) : e[EXP_W-1:0];
  assign r_man = (zero | unf) ? '0 : ovf ? '1 : m_core;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      bus.sign_out <= 1'b0;
      bus.exp_out <= '0;
      bus.mantissa_out <= '0;
      bus.ovf_out <= 1'b0;
      bus.unf_out <= 1'b0;
    end else begin
      if (bus.in_ready) s1_v <= bus.in_valid;
      if (s1_adv) s2_v <= s1_v;
      if (s1_adv & s1_v) begin
        bus.sign_out <= s1_sign;
        bus.exp_out <= r_exp;
        bus.mantissa_out <= r_man;
        bus.ovf_out <= ovf;
        bus.unf_out <= unf;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (deliver & bus.ovf_out & ~&ovf_cnt) ovf_cnt <= ovf_cnt + CNT_W'(1);
      if (deliver & bus.unf_out & ~&unf_cnt) unf_cnt <= unf_cnt + CNT_W'(1);
    end
endmodule

// File: doc/fp_mul_lp_pipe.md
FP_MUL_LP_PIPE -- requirements
Module: fp_mul_lp_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (>=4).
REQ-002 Parameter MAN_W, default 23, stored mantissa field width (>=4).
REQ-003 Parameter CNT_W, default 16, width of the saturation event counters.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  operand pair present.
REQ-007 in_ready  out  1  block accepts operand pair this cycle.
REQ-008 sign_x, sign_y  in  1 each  operand signs.
REQ-009 exp_x, exp_y  in  EXP_W each  biased exponents.
REQ-010 mantissa_x, mantissa_y  in  MAN_W each  fractional mantissas (hidden 1 implied).
REQ-011 mode  in  1  0 = exact truncated product, 1 = approximate log-product; sampled with operands.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts result this cycle.
REQ-014 sign_out, exp_out, mantissa_out  out  1 / EXP_W / MAN_W  result fields.
REQ-015 ovf_out, unf_out  out  1 each  result was saturated high / clamped low.
REQ-016 cnt_clr  in  1  synchronous clear of both event counters.
REQ-017 ovf_cnt, unf_cnt  out  CNT_W each  count of delivered results with ovf_out / unf_out.

Function
REQ-018 Transfer on in_valid&in_ready (accept) and out_valid&out_ready (deliver); nothing else moves data.
REQ-019 Two register stages S1, S2; unstalled latency = 2 cycles accept-to-out_valid; throughput 1/cycle.
REQ-020 in_ready = ~S1.valid | S1 advances; S1 advances when ~S2.valid | out_ready; no combinational in_valid->in_ready path.
REQ-021 Stall holds all stage contents unchanged; order preserved; no drop, no duplicate.
REQ-022 sign_out = sign_x ^ sign_y in all cases.
REQ-023 Exact mode: P = (1.mx)*(1.my), 2*MAN_W+2 bits; shift = P MSB; mantissa = MAN_W bits below leading one, truncated.
REQ-024 Approx mode: s = mx + my (MAN_W+1 bits); if s < 2^MAN_W, mantissa = s, shift 0; else mantissa = s - 2^MAN_W, shift 1.
REQ-025 Exponent e = exp_x + exp_y - BIAS + shift, signed EXP_W+2 bits, BIAS = 2^(EXP_W-1)-1; no wrap.
REQ-026 e >= 2^EXP_W-1: exp_out = 2^EXP_W-2, mantissa all ones, ovf_out = 1.
REQ-027 e <= 0: exp_out = 1, mantissa 0, unf_out = 1.
REQ-028 exp_x == 0 or exp_y == 0: result zero (exp_out 0, mantissa 0), ovf/unf 0; zero has priority over REQ-026/027.
REQ-029 Counters increment on delivery only, saturate at all ones; cnt_clr wins over a same-cycle increment.

Reset
REQ-030 rst_n low: S1/S2 valid 0, out_valid 0, counters 0, data outputs 0, ovf/unf 0; in_ready 1 one cycle after deassertion at the latest.
REQ-031 Reset mid-operation discards in-flight results; none delivered after release.

Structure
REQ-032 Package fp_lp_pkg holds the mode encoding (MODE_EXACT = 0, MODE_APPROX = 1) and a BIAS function of EXP_W.
REQ-033 Combinational mantissa core in sub-module fp_lp_mant_unit (inputs mx, my, mode; outputs mantissa, shift), parametrised by MAN_W.

Verification
REQ-034 exp 127/127, mantissa 0x400000 both, mode 0 -> exp_out 128, mantissa 0x100000, flags 0, out_valid 2 cycles after accept.
REQ-035 Same operands, mode 1 -> exp_out 128, mantissa 0x000000.
REQ-036 exp 200/200, any mantissa -> exp_out 0xFE, mantissa 0x7FFFFF, ovf_out 1, ovf_cnt +1 on delivery.
REQ-037 exp 60/60 -> exp_out 0x01, mantissa 0, unf_out 1; exp_x 0 -> exp_out 0, mantissa 0, flags 0.
REQ-038 Back-to-back stream of 5 with out_ready low 3 cycles -> in_ready low after 2 held, all 5 delivered in order, no loss.
REQ-039 rst_n pulsed with 2 in flight -> no out_valid after release; counters 0; next accepted op correct.
